// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, a one-entry holding
// register (valid/ready), and single-cycle framing-error / overrun pulses.
module uart_rx #(
  parameter int CLK_HZ  = 50000000,
  parameter int BAUD    = 115200,
  parameter int DIVISOR = CLK_HZ / BAUD,
  parameter int HALF    = DIVISOR / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  // Counter wide enough to hold DIVISOR-1 (and HALF-1, which is smaller).
  localparam int CW = $clog2(DIVISOR + 1);
  localparam logic [CW-1:0] RELOAD    = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t        state_reg;
  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          rxd_s;
  logic          expiry;

  assign rxd_s   = sync_reg[1];
  assign expiry  = (cnt_reg == '0);
  // Decoded straight from the state flop, so it carries no combinational input path.
  assign rx_busy = (state_reg != IDLE);

  // Two-flop synchronizer on the asynchronous line; resets to the idle level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rxd};
    end
  end

  // Receive FSM, baud counter, shift register and holding-register handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumer drain; a delivery later in this block takes precedence.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      // Baud counter runs only while a frame is being timed.
      if (state_reg == START || state_reg == DATA || state_reg == STOP) begin
        cnt_reg <= expiry ? RELOAD : (cnt_reg - CNT_ONE);
      end

      case (state_reg)
        IDLE: begin
          if (!rxd_s) begin
            cnt_reg   <= HALF_LOAD;
            state_reg <= START;
          end
        end

        START: begin
          if (expiry) begin
            if (!rxd_s) begin
              bit_reg   <= '0;
              state_reg <= DATA;
            end else begin
              // Line went back high before mid-start-bit: a glitch.
              state_reg <= IDLE;
            end
          end
        end

        DATA: begin
          if (expiry) begin
            shift_reg <= {rxd_s, shift_reg[7:1]};
            bit_reg   <= bit_reg + 3'd1;
            if (bit_reg == 3'd7) begin
              state_reg <= STOP;
            end
          end
        end

        STOP: begin
          if (expiry) begin
            if (rxd_s) begin
              state_reg <= IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                // Holding register full and not draining: drop the new byte.
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state_reg <= BREAK;
            end
          end
        end

        BREAK: begin
          // Hold off until the line returns high so a stuck-low line yields nothing.
          if (rxd_s) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios for uart_rx at a reduced divisor
// (1.7 MHz / 100 kbaud -> 17 clocks per bit, half-bit 8).
module tb_uart_rx;

  localparam int CLK_HZ   = 1700000;
  localparam int BAUD     = 100000;
  localparam int DIV      = 17;
  localparam int HALF     = 8;
  // Start driven after edge k: two sync flops, detection at edge k+3,
  // stop bit sampled at k+3+HALF+9*DIV, outputs visible right after that edge.
  localparam int STOP_OFS = 3 + HALF + 9 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cnt = 0;
  int rise_cyc = -1;
  int fe_cnt = 0;
  int fe_cyc = -1;
  int ov_cnt = 0;
  int ov_cyc = -1;
  logic valid_q = 1'b0;
  logic [7:0] hs_q[$];

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid && !valid_q) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
      $display("rx byte %02h valid at cycle %0d", rx_data, cyc);
    end
    valid_q = rx_valid;
    if (frame_err) begin
      fe_cnt = fe_cnt + 1;
      fe_cyc = cyc;
      $display("frame_err pulse at cycle %0d", cyc);
    end
    if (overrun) begin
      ov_cnt = ov_cnt + 1;
      ov_cyc = cyc;
      $display("overrun pulse at cycle %0d", cyc);
    end
    if (rx_valid && rx_ready) hs_q.push_back(rx_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  // Caller is positioned at posedge+1; k is the edge after which the start bit begins.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int k);
    k = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", rx_busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", overrun); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int k, r0, f0, o0;
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    rx_ready = 1'b0;
    send_frame(8'h45, 1'b1, k);
    checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL single_rise got %0d want 1", rise_cnt - r0); end
    checks++; if (rise_cyc != k + STOP_OFS) begin errors++; $display("FAIL single_latency got %0d want %0d", rise_cyc, k + STOP_OFS); end
    checks++; if (rx_data !== 8'h45) begin errors++; $display("FAIL single_data got %h want 45", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", rx_valid); end
    checks++; if (fe_cnt != f0 || ov_cnt != o0) begin errors++; $display("FAIL single_flags got fe %0d ov %0d want 0 0", fe_cnt - f0, ov_cnt - o0); end
    drain();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h45) begin errors++; $display("FAIL single_hold got %h want 45", rx_data); end
  endtask

  task automatic test_glitch();
    int k, r0, f0, t_end;
    r0 = rise_cnt; f0 = fe_cnt;
    k = cyc;
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rxd = 1'b1;
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got %b want 1", rx_busy); end
    t_end = -1;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (!rx_busy) begin
        t_end = cyc;
        break;
      end
    end
    checks++; if (t_end != k + 3 + HALF) begin errors++; $display("FAIL glitch_abort got %0d want %0d", t_end, k + 3 + HALF); end
    repeat (2 * DIV) @(posedge clk);
    #1;
    checks++; if (rise_cnt != r0 || rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_novalid got %0d want 0", rise_cnt - r0); end
    checks++; if (fe_cnt != f0) begin errors++; $display("FAIL glitch_noferr got %0d want 0", fe_cnt - f0); end
    $display("glitch of 4 cycles rejected");
  endtask

  task automatic test_break();
    int k, r0, f0;
    r0 = rise_cnt; f0 = fe_cnt;
    send_frame(8'hA5, 1'b0, k);
    repeat (2000) @(posedge clk);
    #1;
    checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL break_ferr_count got %0d want 1", fe_cnt - f0); end
    checks++; if (fe_cyc != k + STOP_OFS) begin errors++; $display("FAIL break_ferr_cycle got %0d want %0d", fe_cyc, k + STOP_OFS); end
    checks++; if (rise_cnt != r0 || rx_valid !== 1'b0) begin errors++; $display("FAIL break_novalid got %0d want 0", rise_cnt - r0); end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL break_held got %b want 1", rx_busy); end
    rxd = 1'b1;
    repeat (DIV) @(posedge clk);
    #1;
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_release got %b want 0", rx_busy); end
    send_frame(8'h3C, 1'b1, k);
    checks++; if (rx_data !== 8'h3C || rx_valid !== 1'b1) begin errors++; $display("FAIL break_next got %h/%b want 3c/1", rx_data, rx_valid); end
    checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL break_next_ferr got %0d want 1", fe_cnt - f0); end
    drain();
  endtask

  task automatic test_back_to_back();
    int k1, k2, o0, s2;
    rx_ready = 1'b0;
    o0 = ov_cnt;
    send_frame(8'h11, 1'b1, k1);
    send_frame(8'h22, 1'b1, k2);
    checks++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_keep got %h/%b want 11/1", rx_data, rx_valid); end
    checks++; if (ov_cnt - o0 != 1) begin errors++; $display("FAIL b2b_ovr_count got %0d want 1", ov_cnt - o0); end
    checks++; if (ov_cyc != k2 + STOP_OFS) begin errors++; $display("FAIL b2b_ovr_cycle got %0d want %0d", ov_cyc, k2 + STOP_OFS); end
    drain();

    o0 = ov_cnt;
    s2 = cyc + 10 * DIV + STOP_OFS;
    fork
      begin
        send_frame(8'h11, 1'b1, k1);
        send_frame(8'h22, 1'b1, k2);
      end
      begin
        wait (cyc == s2 - 1);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
      end
    join
    checks++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_replace got %h/%b want 22/1", rx_data, rx_valid); end
    checks++; if (ov_cnt != o0) begin errors++; $display("FAIL b2b_no_ovr got %0d want 0", ov_cnt - o0); end
    drain();
  endtask

  task automatic test_reset_mid();
    int k, r0, f0, o0;
    logic [7:0] d;
    d = 8'hF0;
    rx_ready = 1'b0;
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rxd = d[4];
    repeat (DIV / 2) @(posedge clk);
    #1;
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", rx_busy); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0 || rx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_state got %b/%b want 0/0", rx_valid, rx_busy); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rstmid_pulse got %b/%b want 0/0", frame_err, overrun); end
    repeat (5 * DIV) @(posedge clk);
    #1;
    checks++; if (rise_cnt != r0 || fe_cnt != f0 || ov_cnt != o0) begin errors++; $display("FAIL rstmid_quiet got %0d/%0d/%0d want 0/0/0", rise_cnt - r0, fe_cnt - f0, ov_cnt - o0); end
    send_frame(8'h0F, 1'b1, k);
    checks++; if (rx_data !== 8'h0F || rx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_next got %h/%b want 0f/1", rx_data, rx_valid); end
    checks++; if (rise_cyc != k + STOP_OFS) begin errors++; $display("FAIL rstmid_latency got %0d want %0d", rise_cyc, k + STOP_OFS); end
    drain();
  endtask

  task automatic test_loopback();
    int k, base, f0, o0;
    logic [7:0] exp_b [3];
    exp_b = '{8'h00, 8'hFF, 8'h55};
    base = hs_q.size();
    f0 = fe_cnt; o0 = ov_cnt;
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, k);
    repeat (4) @(posedge clk);
    #1;
    rx_ready = 1'b0;
    checks++; if (hs_q.size() - base != 3) begin errors++; $display("FAIL loop_count got %0d want 3", hs_q.size() - base); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (base + i >= hs_q.size()) begin
        errors++; $display("FAIL loop_byte%0d got none want %h", i, exp_b[i]);
      end else if (hs_q[base + i] !== exp_b[i]) begin
        errors++; $display("FAIL loop_byte%0d got %h want %h", i, hs_q[base + i], exp_b[i]);
      end
    end
    checks++; if (fe_cnt != f0 || ov_cnt != o0) begin errors++; $display("FAIL loop_flags got fe %0d ov %0d want 0 0", fe_cnt - f0, ov_cnt - o0); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL loop_drained got %b want 0", rx_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: recovers bytes from a serial line using mid-bit sampling.
- Mirrors the team's 8N1 transmitter at the same baud divisor (50 MHz / 115200).
- Presents each received byte in a one-entry holding register with a valid/ready handshake.
- Flags framing errors and overruns. Sits between the board rxd pin and any byte consumer, or in loopback with the transmitter.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- DIVISOR, CLK_HZ/BAUD (integer truncation, 434 at defaults), clocks per bit.
- HALF, DIVISOR/2 (217 at defaults), clocks from start-edge detection to the start-bit sample.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- rxd  in  1  asynchronous serial input, idle high.
- rx_data  out  8  received byte, valid while rx_valid=1.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts the byte when rx_valid&rx_ready in the same cycle.
- rx_busy  out  1  high in any state other than IDLE.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while the holding register was full and not being drained.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; rx_data=0x00; rx_valid=0; frame_err=0; overrun=0; rx_busy=0.
  - Synchronizer flops are set to 1; bit counter and baud counter are cleared.
  - Reset mid-frame abandons the partial byte; no pulse is generated.
- Input sync: rxd passes through 2 flops to give rxd_s. All decisions use rxd_s only. Adds 2 cycles of latency.
- Baud counter: a down-counter. An "expiry" is the cycle it equals 0; at expiry it reloads DIVISOR-1.
- States:
  - IDLE: when rxd_s=0, load counter with HALF-1 and go to START.
  - START: at expiry, if rxd_s=0, clear bit index and go to DATA. If rxd_s=1, treat it as a glitch and return to IDLE; no outputs change.
  - DATA: at each expiry, shift rxd_s in LSB-first (shift right, new bit into bit 7) and increment the bit index. After the 8th sample, go to STOP.
  - STOP, at expiry:
    - rxd_s=1: deliver the byte (see holding register) and go to IDLE.
    - rxd_s=0: pulse frame_err for 1 cycle, discard the byte, go to BREAK.
  - BREAK: wait for rxd_s=1, then go to IDLE. This prevents a held-low line from producing spurious bytes.
- Sample timing: with start detected at cycle t, the start bit is sampled at t+HALF. Data bit i (0..7) is sampled at t+HALF+(i+1)*DIVISOR. The stop bit is sampled at t+HALF+9*DIVISOR.
- Holding register, on delivery (the stop-bit expiry cycle, call it s):
  - rx_valid=0: rx_data<=byte and rx_valid<=1, visible at s+1.
  - rx_valid=1 and rx_ready=1 in cycle s: the new byte replaces the old one and rx_valid stays 1. No overrun.
  - rx_valid=1 and rx_ready=0: overrun pulses at s+1; the new byte is dropped and the old rx_data/rx_valid are kept.
  - Otherwise, rx_valid&rx_ready clears rx_valid on the next cycle. rx_data holds its last value.
- Re-arm: IDLE accepts a new start edge on the cycle after returning from STOP. This allows back-to-back frames with a single stop bit.
- rx_ready while rx_valid=0 is ignored.

Test Plan:
- 0x45 sent at 115200 baud (434 clk/bit, 1 stop bit) -> rx_valid rises 1 cycle after stop sample, rx_data=0x45, frame_err=0, overrun=0; rx_ready=1 clears rx_valid the next cycle.
- rxd low for 100 cycles, then high -> START aborts at the HALF sample, back to IDLE, no rx_valid, no frame_err.
- Frame 0xA5 with stop bit driven low, line held low for 2000 cycles, then high -> one frame_err pulse, rx_valid stays 0, FSM stays in BREAK until high; a following 0x3C frame is received correctly.
- Back-to-back 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11, single overrun pulse at the second stop sample, rx_data still 0x11. Repeat with rx_ready=1 exactly at the second stop sample -> rx_data=0x22, no overrun.
- rst_n=0 for 1 cycle during bit 4 of 0xF0 -> all outputs 0 next cycle, no pulses; the next full frame 0x0F is received correctly.
- Loopback from the team's transmitter sending 0x00, 0xFF, 0x55 consecutively -> three rx_valid handshakes with matching data, no errors.
